// File: rtl/vector_sequencer.sv
// Block sequencer for a 4-lane pixel pipeline: per block, read/multiply into
// mult_mem, then sum into sum_mem, with pause, abort and done handshake.
module vector_sequencer #(
    parameter int unsigned N_BLOCKS = 16,
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned LANE_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        abort,
    output logic        vec_func,
    output logic        w_mem_2,
    output logic        w_mem_3,
    output logic [15:0] blk_idx,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_MUL_RD = 3'd1;
    localparam logic [2:0] S_MUL_WR = 3'd2;
    localparam logic [2:0] S_SUM_RD = 3'd3;
    localparam logic [2:0] S_SUM_WR = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;
    localparam logic [2:0] S_FIN    = 3'd6;

    // The wait counter counts down to zero, so it is loaded with latency-1.
    localparam logic [2:0]  MEM_LOAD  = 3'(MEM_LAT - 1);
    localparam logic [2:0]  LANE_LOAD = 3'(LANE_LAT - 1);
    localparam logic [15:0] LAST_BLK  = 16'(N_BLOCKS - 1);

    logic [2:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] blk_idx_q, blk_idx_d;
    logic        live;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        blk_idx_d = blk_idx_q;

        if (abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            cnt_d     = 3'd0;
            blk_idx_d = 16'd0;
        end else if (!pause) begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_d   = S_MUL_RD;
                        cnt_d     = MEM_LOAD;
                        blk_idx_d = 16'd0;
                    end
                end
                S_MUL_RD: begin
                    if (cnt_q == 3'd0) state_d = S_MUL_WR;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                S_MUL_WR: begin
                    state_d = S_SUM_RD;
                    cnt_d   = LANE_LOAD;
                end
                S_SUM_RD: begin
                    if (cnt_q == 3'd0) state_d = S_SUM_WR;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                S_SUM_WR: state_d = S_NEXT;
                S_NEXT: begin
                    if (blk_idx_q == LAST_BLK) begin
                        state_d = S_FIN;
                    end else begin
                        state_d   = S_MUL_RD;
                        cnt_d     = MEM_LOAD;
                        blk_idx_d = blk_idx_q + 16'd1;
                    end
                end
                S_FIN:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            blk_idx_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            blk_idx_q <= blk_idx_d;
        end
    end

    // Strobes and done are decoded from the state register, so they fall
    // as soon as reset asserts and are masked while paused or aborting.
    assign live     = !pause && !abort;
    assign w_mem_2  = (state_q == S_MUL_WR) && live;
    assign w_mem_3  = (state_q == S_SUM_WR) && live;
    assign done     = (state_q == S_FIN) && live;
    assign vec_func = (state_q == S_SUM_RD) || (state_q == S_SUM_WR);
    assign busy     = (state_q != S_IDLE);
    assign blk_idx  = blk_idx_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// Bench for vector_sequencer: three parameterisations, a scenario table with
// a timing-derived event scoreboard, plus hand-written pause/reset sequences.
module tb_vector_sequencer;

    typedef struct {
        int sel;
        int n;
        int mem;
        int lane;
        int pa;
        int plen;
        int abort_at;
        int jobs;
        int exp_done;
        int exp_w2;
    } scen_t;

    typedef struct {
        int cyc;
        int kind;
        int blk;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_s = 1'b0;
    logic        pause_s = 1'b0;
    logic        abort_s = 1'b0;
    int          sel_s = 0;

    logic        vf_v [3];
    logic        w2_v [3];
    logic        w3_v [3];
    logic [15:0] blk_v [3];
    logic        busy_v [3];
    logic        done_v [3];

    logic        w2, w3, dn, bsy;
    logic [15:0] blk;

    int checks = 0;
    int errors = 0;
    ev_t exp_q[$];
    scen_t tbl[8];

    always #5 clk = ~clk;

    vector_sequencer #(.N_BLOCKS(4), .MEM_LAT(1), .LANE_LAT(1)) u_a (
        .clk(clk), .rst(rst),
        .start(start_s && sel_s == 0), .pause(pause_s && sel_s == 0), .abort(abort_s && sel_s == 0),
        .vec_func(vf_v[0]), .w_mem_2(w2_v[0]), .w_mem_3(w3_v[0]),
        .blk_idx(blk_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    vector_sequencer #(.N_BLOCKS(2), .MEM_LAT(3), .LANE_LAT(2)) u_b (
        .clk(clk), .rst(rst),
        .start(start_s && sel_s == 1), .pause(pause_s && sel_s == 1), .abort(abort_s && sel_s == 1),
        .vec_func(vf_v[1]), .w_mem_2(w2_v[1]), .w_mem_3(w3_v[1]),
        .blk_idx(blk_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    vector_sequencer u_c (
        .clk(clk), .rst(rst),
        .start(start_s && sel_s == 2), .pause(pause_s && sel_s == 2), .abort(abort_s && sel_s == 2),
        .vec_func(vf_v[2]), .w_mem_2(w2_v[2]), .w_mem_3(w3_v[2]),
        .blk_idx(blk_v[2]), .busy(busy_v[2]), .done(done_v[2])
    );

    always_comb begin
        w2  = w2_v[sel_s];
        w3  = w3_v[sel_s];
        dn  = done_v[sel_s];
        bsy = busy_v[sel_s];
        blk = blk_v[sel_s];
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic pop_event(input int kind, input int c);
        ev_t e;
        if (exp_q.size() == 0) begin
            check($sformatf("unexpected_kind%0d_at_cycle", kind), c, -1);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("kind_at_cycle%0d", c), kind, e.kind);
            check($sformatf("cycle_of_kind%0d", kind), c, e.cyc);
            check($sformatf("blk_idx_kind%0d_cycle%0d", kind, c), int'(blk), e.blk);
        end
    endtask

    // Expected strobe cycles come from the block timing: within a block of
    // MEM_LAT+LANE_LAT+3 cycles, w_mem_2 is at MEM_LAT+1 and w_mem_3 at
    // MEM_LAT+LANE_LAT+2; done follows the last block by one cycle.
    task automatic run_scen(input scen_t s);
        int per, t, tp, last, off, x, done_seen, w2_cnt, rel, jdx;
        bit exp_busy;
        ev_t e;
        per = s.mem + s.lane + 3;
        t   = s.n * per + 1;
        tp  = t + s.plen;
        exp_q.delete();
        for (int j = 0; j < s.jobs; j++) begin
            off = j * (tp + 1);
            for (int b = 0; b < s.n; b++) begin
                for (int k = 2; k <= 3; k++) begin
                    x = b * per + s.mem + 1 + (k == 3 ? s.lane + 1 : 0);
                    if (s.plen > 0 && x >= s.pa) x += s.plen;
                    e.cyc = off + x; e.kind = k; e.blk = b;
                    if (s.abort_at < 0 || e.cyc < s.abort_at) exp_q.push_back(e);
                end
            end
            if (s.abort_at < 0) begin
                e.cyc = off + tp; e.kind = 4; e.blk = s.n - 1;
                exp_q.push_back(e);
            end
        end

        @(posedge clk); #1;
        sel_s = s.sel; start_s = 1'b1; pause_s = 1'b0; abort_s = 1'b0;
        last = (s.abort_at >= 0) ? s.abort_at + 3 : s.jobs * (tp + 1) + 1;
        done_seen = -1;
        w2_cnt = 0;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            start_s = (c <= (s.jobs - 1) * (tp + 1));
            pause_s = (s.plen > 0 && c >= s.pa && c < s.pa + s.plen);
            abort_s = (c == s.abort_at);
            @(negedge clk);
            if (w2) begin pop_event(2, c); w2_cnt++; end
            if (w3) pop_event(3, c);
            if (dn) begin
                pop_event(4, c);
                if (done_seen < 0) done_seen = c;
            end
            jdx = (c - 1) / (tp + 1);
            rel = c - jdx * (tp + 1);
            exp_busy = (jdx < s.jobs) && rel >= 1 && rel <= tp &&
                       (s.abort_at < 0 || c <= s.abort_at);
            check($sformatf("busy_s%0d_c%0d", s.sel, c), int'(bsy), int'(exp_busy));
            if (c == s.abort_at + 1) check("blk_idx_after_abort", int'(blk), 0);
        end
        start_s = 1'b0; pause_s = 1'b0; abort_s = 1'b0;
        check("done_cycle", done_seen, s.exp_done);
        check("w_mem_2_count", w2_cnt, s.exp_w2);
        check("events_left", exp_q.size(), 0);
        if (s.abort_at < 0) check("blk_idx_held", int'(blk), s.n - 1);
    endtask

    initial begin
        //          sel n  mem lane pa  plen abort jobs done w2
        tbl[0] = '{0, 4,  1, 1,  0,  0,  -1,  1,  21,  4};
        tbl[1] = '{1, 2,  3, 2,  0,  0,  -1,  1,  17,  2};
        tbl[2] = '{2, 16, 1, 1,  4,  5,  -1,  1,  86,  16};
        tbl[3] = '{0, 4,  1, 1,  0,  0,  11,  1,  -1,  2};
        tbl[4] = '{0, 4,  1, 1,  0,  0,  -1,  1,  21,  4};
        tbl[5] = '{0, 4,  1, 1,  0,  0,  -1,  2,  21,  8};
        tbl[6] = '{1, 2,  3, 2,  17, 3,  -1,  1,  20,  2};
        tbl[7] = '{0, 4,  1, 1,  3,  2,  -1,  1,  23,  4};

        #12;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_busy%0d", k), int'(busy_v[k]), 0);
            check($sformatf("rst_strobes%0d", k), int'({w2_v[k], w3_v[k], done_v[k], vf_v[k]}), 0);
            check($sformatf("rst_blk%0d", k), int'(blk_v[k]), 0);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 8; i++) run_scen(tbl[i]);

        // pause held in IDLE blocks start acceptance
        @(posedge clk); #1;
        sel_s = 0; start_s = 1'b1; pause_s = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("idle_pause_busy", int'(bsy), 0);
            @(posedge clk); #1;
        end
        start_s = 1'b0; pause_s = 1'b0;
        @(negedge clk);
        check("idle_pause_busy_after", int'(bsy), 0);

        // asynchronous reset during MUL_WR
        @(posedge clk); #1;
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("mul_wr_strobe_before_rst", int'(w2), 1);
        #1 rst = 1'b0;
        #1;
        check("rst_async_w2", int'(w2), 0);
        check("rst_async_busy", int'(bsy), 0);
        check("rst_async_blk", int'(blk), 0);
        @(posedge clk); #3;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_quiet", int'({w2, w3, dn, bsy}), 0);
        end
        run_scen(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
